sm_addsub_arbiter: RTL



---
 rtl/sm_addsub_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sm_addsub_arbiter.sv
// Round-robin front end that shares one pipelined sign-magnitude add/sub datapath
// between two requesters, tagging every operation so its result returns to the issuer.
module sm_addsub_arbiter #(
    parameter int LATENCY = 7,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_sel,
    input  logic [5:0]       req0_a,
    input  logic [5:0]       req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_sel,
    input  logic [5:0]       req1_a,
    input  logic [5:0]       req1_b,
    output logic             dp_select,
    output logic [5:0]       dp_a,
    output logic [5:0]       dp_b,
    input  logic [6:0]       dp_s,
    output logic             rsp0_valid,
    output logic [6:0]       rsp0_data,
    output logic             rsp1_valid,
    output logic [6:0]       rsp1_data,
    output logic             idle
);

    localparam int STAGES = LATENCY + 1;
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              ptr_r;
    logic [STAGES-1:0] tag_v_r;
    logic [STAGES-1:0] tag_id_r;
    logic [CNT_W-1:0]  outst0_r;
    logic [CNT_W-1:0]  outst1_r;
    logic [CNT_W-1:0]  outst0_nxt_s;
    logic [CNT_W-1:0]  outst1_nxt_s;
    logic              elig0_s;
    logic              elig1_s;
    logic              grant0_s;
    logic              grant1_s;
    logic              accept_s;
    logic              ret0_s;
    logic              ret1_s;

    // Credit update: +1 on accept, -1 on return, both at once cancel; saturates at zero.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cur + CNT_ONE;
            2'b01:   nxt = (cur != CNT_ZERO) ? (cur - CNT_ONE) : cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    assign elig0_s = req0_valid && (outst0_r < MAX_OUT_C);
    assign elig1_s = req1_valid && (outst1_r < MAX_OUT_C);

    // Round-robin grant; the pointer only matters when both requesters are eligible.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (elig0_s && elig1_s) begin
            if (ptr_r) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else if (elig0_s) begin
            grant0_s = 1'b1;
        end else if (elig1_s) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s   = grant0_s | grant1_s;
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // The last tag stage lines up with dp_s carrying that operation's result.
    assign ret0_s = tag_v_r[STAGES-1] && !tag_id_r[STAGES-1];
    assign ret1_s = tag_v_r[STAGES-1] &&  tag_id_r[STAGES-1];

    // Next-state of the per-requester credit counters.
    always_comb begin
        outst0_nxt_s = cnt_next(outst0_r, grant0_s, ret0_s);
        outst1_nxt_s = cnt_next(outst1_r, grant1_s, ret1_s);
    end

    // Arbitration pointer and datapath operand registers, loaded on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r     <= 1'b0;
            dp_select <= 1'b0;
            dp_a      <= 6'd0;
            dp_b      <= 6'd0;
        end else if (grant0_s) begin
            ptr_r     <= 1'b1;
            dp_select <= req0_sel;
            dp_a      <= req0_a;
            dp_b      <= req0_b;
        end else if (grant1_s) begin
            ptr_r     <= 1'b0;
            dp_select <= req1_sel;
            dp_a      <= req1_a;
            dp_b      <= req1_b;
        end
    end

    // Tag shift register tracking which requester owns each in-flight slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v_r  <= {STAGES{1'b0}};
            tag_id_r <= {STAGES{1'b0}};
        end else begin
            tag_v_r  <= {tag_v_r[STAGES-2:0], accept_s};
            tag_id_r <= {tag_id_r[STAGES-2:0], grant1_s};
        end
    end

    // Response routing: single-cycle valid pulse, data holds between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= 7'd0;
            rsp1_valid <= 1'b0;
            rsp1_data  <= 7'd0;
        end else begin
            rsp0_valid <= ret0_s;
            rsp1_valid <= ret1_s;
            if (ret0_s) begin
                rsp0_data <= dp_s;
            end
            if (ret1_s) begin
                rsp1_data <= dp_s;
            end
        end
    end

    // Credit counters and the idle flag derived from their next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst0_r <= CNT_ZERO;
            outst1_r <= CNT_ZERO;
            idle     <= 1'b1;
        end else begin
            outst0_r <= outst0_nxt_s;
            outst1_r <= outst1_nxt_s;
            idle     <= (outst0_nxt_s == CNT_ZERO) && (outst1_nxt_s == CNT_ZERO);
        end
    end

endmodule
